// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared defaults and slice helper for the inverse PWM capture blocks
// Purpose: default period width / averaging depth, and the flattened-bus offset helper
// used wherever a per-channel field is packed into one wide vector.
package knight_pkg;

  localparam int PWM_WIDTH_DEF = 11;
  localparam int PWM_AVG_DEF   = 0;

  // Bit offset of field ch in a vector of equally sized fields of the given width.
  function automatic int pwm_idx(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/inverse_pwm_multi_if.sv
// rtl/inverse_pwm_multi_if.sv - capture-control and result bus of inverse_pwm_multi
// Purpose: groups enable, raw PWM inputs and the registered results.
//   en        capture enable (driven by master)
//   PWM_sig   raw asynchronous PWM inputs, one bit per channel (driven by master)
//   duty_out  per-channel high count, channel i at [i*WIDTH +: WIDTH]
//   diff_out  signed pair difference, pair p at [p*(WIDTH+1) +: WIDTH+1]
//   stuck     1 = channel had no transition during the last window
//   vld       one-cycle strobe marking new results
interface inverse_pwm_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = knight_pkg::PWM_WIDTH_DEF
);

  logic                              en;
  logic [NUM_CH-1:0]                 PWM_sig;
  logic [NUM_CH*WIDTH-1:0]           duty_out;
  logic [(NUM_CH/2)*(WIDTH+1)-1:0]   diff_out;
  logic [NUM_CH-1:0]                 stuck;
  logic                              vld;

  modport master (
    output en, PWM_sig,
    input  duty_out, diff_out, stuck, vld
  );

  modport slave (
    input  en, PWM_sig,
    output duty_out, diff_out, stuck, vld
  );

endinterface

// File: rtl/pwm_chan_acc.sv
// rtl/pwm_chan_acc.sv - single-channel synchronizer, high-time accumulator and edge flag
// Purpose: counts synchronized high cycles over one averaging window and remembers
// whether the channel toggled in that window.
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        capture enable; low clears accumulator and edge flag
//   pb_i        period boundary cycle (not counted)
//   we_i        window end cycle (clears accumulator and edge flag)
//   pwm_i       raw asynchronous PWM input
//   duty_o      accumulator divided by 2^AVG_LOG2 (truncating)
//   seen_o      1 = a transition was observed in the current window
module pwm_chan_acc import knight_pkg::*; #(
  parameter int WIDTH       = PWM_WIDTH_DEF,
  parameter int AVG_LOG2    = PWM_AVG_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             pb_i,
  input  logic             we_i,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] duty_o,
  output logic             seen_o
);

  localparam int AW = WIDTH + AVG_LOG2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pwm_s;
  logic [AW-1:0]          acc_q, acc_d;
  logic                   seen_q, seen_d;

  assign pwm_s = sync_q[SYNC_STAGES-1];

  // Clear wins over a same-cycle high sample or edge at the window end.
  always_comb begin
    acc_d  = acc_q;
    seen_d = seen_q;
    if (!en_i || we_i) begin
      acc_d  = '0;
      seen_d = 1'b0;
    end else begin
      if (!pb_i) begin
        acc_d = acc_q + AW'(pwm_s);
      end
      if (pwm_s != prev_q) begin
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      acc_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q <= pwm_s;
      acc_q  <= acc_d;
      seen_q <= seen_d;
    end
  end

  assign duty_o = acc_q[AW-1:AVG_LOG2];
  assign seen_o = seen_q;

endmodule

// File: rtl/inverse_pwm_multi.sv
// rtl/inverse_pwm_multi.sv - multi-channel PWM duty capture with averaging and pair differences
// Purpose: measures high time per channel over 2^WIDTH-cycle periods, optionally averaged
// over 2^AVG_LOG2 periods, and reports per-pair signed differences and stuck channels.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         inverse_pwm_multi_if slave: en, PWM_sig in; duty_out, diff_out, stuck, vld out
module inverse_pwm_multi import knight_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = PWM_WIDTH_DEF,
  parameter int AVG_LOG2    = PWM_AVG_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  inverse_pwm_multi_if.slave  bus
);

  localparam int NP = NUM_CH / 2;
  localparam int DW = WIDTH + 1;

  if (NUM_CH % 2 != 0) begin : g_bad_num_ch
    $error("inverse_pwm_multi: NUM_CH must be even");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("inverse_pwm_multi: SYNC_STAGES must be at least 2");
  end

  logic [WIDTH-1:0]        per_cnt_q, per_cnt_d;
  logic                    pb;
  logic                    we;
  logic [NUM_CH*WIDTH-1:0] trunc;
  logic [NUM_CH-1:0]       seen;

  logic [NUM_CH*WIDTH-1:0] duty_q, duty_d;
  logic [NP*DW-1:0]        diff_q, diff_d;
  logic [NUM_CH-1:0]       stuck_q, stuck_d;
  logic                    vld_q, vld_d;

  always_comb begin
    per_cnt_d = '0;
    if (bus.en) begin
      per_cnt_d = per_cnt_q + WIDTH'(1);
    end
  end

  assign pb = bus.en & (&per_cnt_q);

  if (AVG_LOG2 > 0) begin : g_win
    logic [AVG_LOG2-1:0] win_cnt_q, win_cnt_d;

    always_comb begin
      win_cnt_d = win_cnt_q;
      if (!bus.en) begin
        win_cnt_d = '0;
      end else if (pb) begin
        win_cnt_d = win_cnt_q + AVG_LOG2'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        win_cnt_q <= '0;
      end else begin
        win_cnt_q <= win_cnt_d;
      end
    end

    assign we = pb & (&win_cnt_q);
  end else begin : g_no_win
    assign we = pb;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pwm_chan_acc #(
      .WIDTH       (WIDTH),
      .AVG_LOG2    (AVG_LOG2),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (bus.en),
      .pb_i   (pb),
      .we_i   (we),
      .pwm_i  (bus.PWM_sig[i]),
      .duty_o (trunc[pwm_idx(i, WIDTH) +: WIDTH]),
      .seen_o (seen[i])
    );
  end

  // Differences use the values being loaded this cycle, not the previous duty_out.
  always_comb begin
    duty_d  = duty_q;
    diff_d  = diff_q;
    stuck_d = stuck_q;
    vld_d   = we;
    if (we) begin
      duty_d  = trunc;
      stuck_d = ~seen;
      for (int p = 0; p < NP; p++) begin
        diff_d[p*DW +: DW] = {1'b0, trunc[pwm_idx(2*p, WIDTH) +: WIDTH]}
                           - {1'b0, trunc[pwm_idx(2*p+1, WIDTH) +: WIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      duty_q    <= '0;
      diff_q    <= '0;
      stuck_q   <= '0;
      vld_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      duty_q    <= duty_d;
      diff_q    <= diff_d;
      stuck_q   <= stuck_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.duty_out = duty_q;
  assign bus.diff_out = diff_q;
  assign bus.stuck    = stuck_q;
  assign bus.vld      = vld_q;

endmodule

// File: tb/tb_inverse_pwm_multi.sv
// tb/tb_inverse_pwm_multi.sv - bench for inverse_pwm_multi (default and 4-period averaging)
module tb_inverse_pwm_multi;

  localparam int P    = 2048;
  localparam int MAXK = 120000;

  logic clk;
  logic rst_n;

  inverse_pwm_multi_if #(.NUM_CH(4), .WIDTH(11)) bus0 ();
  inverse_pwm_multi_if #(.NUM_CH(4), .WIDTH(11)) bus1 ();

  assign bus1.en      = bus0.en;
  assign bus1.PWM_sig = bus0.PWM_sig;

  inverse_pwm_multi #(.NUM_CH(4), .WIDTH(11), .AVG_LOG2(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  inverse_pwm_multi #(.NUM_CH(4), .WIDTH(11), .AVG_LOG2(2), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Stimulus configuration: 0 low, 1 high, 2 pulse (hia/hib alternate per period), 3 random toggle
  int mode [4];
  int hia  [4];
  int hib  [4];
  int phs  [4];
  int tc     = 0;
  int t_base = 0;

  initial begin
    logic [3:0] v;
    int t, ph, hl;
    bus0.PWM_sig = 4'b0;
    forever begin
      @(posedge clk);
      #1;
      t = tc - t_base;
      v = bus0.PWM_sig;
      for (int ch = 0; ch < 4; ch++) begin
        case (mode[ch])
          0: v[ch] = 1'b0;
          1: v[ch] = 1'b1;
          2: begin
            ph = t % P;
            hl = (((t / P) % 2) != 0) ? hib[ch] : hia[ch];
            v[ch] = (ph >= phs[ch]) && (ph < phs[ch] + hl);
          end
          default: v[ch] = ($urandom_range(0, 7) == 0) ? ~v[ch] : v[ch];
        endcase
      end
      bus0.PWM_sig = v;
      tc++;
    end
  end

  // Reference model: per-edge sample history; a window is LEN consecutive enabled edges
  // starting at the first enabled edge; the last edge of every 2048 is not counted.
  int         len_d [2] = '{2048, 8192};
  int         avg_d [2] = '{0, 2};
  logic [3:0] hist  [MAXK];
  int         k  = 0;
  int         rk = 0;
  int         off   [2];
  int         cnt   [2][4];
  logic [3:0] seen_m[2];
  logic [43:0] exp_duty [2];
  logic [23:0] exp_diff [2];
  logic [3:0]  exp_stuck[2];
  logic        exp_vld  [2];

  initial begin
    logic [3:0] s, pv;
    int dd [4];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rk = k;
        for (int d = 0; d < 2; d++) begin
          off[d] = 0;
          seen_m[d] = 4'b0;
          for (int ch = 0; ch < 4; ch++) cnt[d][ch] = 0;
          exp_duty[d] = '0; exp_diff[d] = '0; exp_stuck[d] = '0; exp_vld[d] = 1'b0;
        end
      end else begin
        if (k < MAXK) hist[k] = bus0.PWM_sig;
        s  = (k - 2 >= rk) ? hist[k-2] : 4'b0;
        pv = (k - 3 >= rk) ? hist[k-3] : 4'b0;
        for (int d = 0; d < 2; d++) begin
          if (!bus0.en) begin
            off[d] = 0; seen_m[d] = 4'b0; exp_vld[d] = 1'b0;
            for (int ch = 0; ch < 4; ch++) cnt[d][ch] = 0;
          end else if (off[d] == len_d[d] - 1) begin
            for (int ch = 0; ch < 4; ch++) begin
              dd[ch] = cnt[d][ch] / (1 << avg_d[d]);
              exp_duty[d][ch*11 +: 11] = 11'(dd[ch]);
              exp_stuck[d][ch] = ~seen_m[d][ch];
              cnt[d][ch] = 0;
            end
            exp_diff[d][11:0]  = 12'(dd[0] - dd[1]);
            exp_diff[d][23:12] = 12'(dd[2] - dd[3]);
            exp_vld[d] = 1'b1; seen_m[d] = 4'b0; off[d] = 0;
          end else begin
            if ((off[d] % P) != P - 1) begin
              for (int ch = 0; ch < 4; ch++) cnt[d][ch] += int'(s[ch]);
            end
            seen_m[d] = seen_m[d] | (s ^ pv);
            off[d]++;
            exp_vld[d] = 1'b0;
          end
        end
        k++;
      end
    end
  end

  task automatic wait_vld(input int d, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (((d == 0) ? bus0.vld : bus1.vld) === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus0.en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus0.duty_out !== '0) begin errs++; $display("FAIL reset_duty: got %h want 0", bus0.duty_out); end
    checks++; if (bus0.diff_out !== '0) begin errs++; $display("FAIL reset_diff: got %h want 0", bus0.diff_out); end
    checks++; if (bus0.stuck !== '0) begin errs++; $display("FAIL reset_stuck: got %b want 0", bus0.stuck); end
    checks++; if (bus0.vld !== 1'b0) begin errs++; $display("FAIL reset_vld: got %b want 0", bus0.vld); end
    checks++; if (bus1.duty_out !== '0) begin errs++; $display("FAIL reset_duty_avg: got %h want 0", bus1.duty_out); end
  endtask

  task automatic test_first_window();
    int n, d1;
    mode = '{1, 2, 3, 0}; hia[1] = 512; hib[1] = 512; phs[1] = 100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bus0.en = 1'b1; t_base = tc;
    wait_vld(0, 3000, n);
    checks++; if (n != 2048) begin errs++; $display("FAIL first_vld_latency: got %0d want 2048", n); end
    checks++; if (bus0.duty_out[10:0] !== 11'd2045) begin errs++; $display("FAIL first_duty_ch0: got %0d want 2045", bus0.duty_out[10:0]); end
    checks++; if (bus0.duty_out !== exp_duty[0]) begin errs++; $display("FAIL first_duty_all: got %h want %h", bus0.duty_out, exp_duty[0]); end
    checks++; if (bus0.stuck !== exp_stuck[0]) begin errs++; $display("FAIL first_stuck: got %b want %b", bus0.stuck, exp_stuck[0]); end
    @(negedge clk);
    checks++; if (bus0.vld !== 1'b0) begin errs++; $display("FAIL vld_one_cycle: got %b want 0", bus0.vld); end
    wait_vld(0, 3000, n);
    checks++; if (n != 2047) begin errs++; $display("FAIL vld_period: got %0d want 2047 after strobe cycle", n); end
    checks++; if (bus0.duty_out[10:0] !== 11'd2047) begin errs++; $display("FAIL high_duty_ch0: got %0d want 2047", bus0.duty_out[10:0]); end
    checks++; if (bus0.stuck[0] !== 1'b1) begin errs++; $display("FAIL stuck_ch0: got %b want 1", bus0.stuck[0]); end
    checks++; if (bus0.stuck[3] !== 1'b1 || bus0.duty_out[43:33] !== 11'd0) begin errs++; $display("FAIL low_ch3: got stuck %b duty %0d want 1 0", bus0.stuck[3], bus0.duty_out[43:33]); end
    d1 = int'(bus0.duty_out[21:11]);
    checks++; if (d1 < 511 || d1 > 513 || bus0.stuck[1] !== 1'b0) begin errs++; $display("FAIL quarter_ch1: got duty %0d stuck %b want 512+-1 0", d1, bus0.stuck[1]); end
    checks++; if (bus0.duty_out !== exp_duty[0] || bus0.diff_out !== exp_diff[0] || bus0.stuck !== exp_stuck[0]) begin
      errs++; $display("FAIL second_window: got %h %h %b want %h %h %b", bus0.duty_out, bus0.diff_out, bus0.stuck, exp_duty[0], exp_diff[0], exp_stuck[0]); end
  endtask

  task automatic test_diff();
    int n, dv;
    mode[0] = 2; mode[1] = 2; phs[0] = 100; phs[1] = 100;
    for (int sw = 0; sw < 2; sw++) begin
      hia[0] = (sw == 0) ? 1536 : 512; hib[0] = hia[0];
      hia[1] = (sw == 0) ? 512 : 1536; hib[1] = hia[1];
      wait_vld(0, 3000, n);
      wait_vld(0, 3000, n);
      dv = $signed(bus0.diff_out[11:0]);
      checks++; if ((sw == 0 && (dv < 1023 || dv > 1025)) || (sw == 1 && (dv < -1025 || dv > -1023))) begin
        errs++; $display("FAIL diff_pair0_sw%0d: got %0d want %0d+-1", sw, dv, (sw == 0) ? 1024 : -1024); end
      checks++; if (bus0.diff_out !== exp_diff[0] || bus0.duty_out !== exp_duty[0]) begin
        errs++; $display("FAIL diff_model_sw%0d: got %h %h want %h %h", sw, bus0.diff_out, bus0.duty_out, exp_diff[0], exp_duty[0]); end
    end
  endtask

  task automatic test_stuck_toggle();
    int n;
    mode[3] = 0;
    wait_vld(0, 3000, n);
    wait_vld(0, 3000, n);
    checks++; if (bus0.stuck[3] !== 1'b1 || bus0.duty_out[43:33] !== 11'd0) begin errs++; $display("FAIL ch3_idle: got stuck %b duty %0d want 1 0", bus0.stuck[3], bus0.duty_out[43:33]); end
    mode[3] = 3;
    wait_vld(0, 3000, n);
    checks++; if (bus0.stuck[3] !== 1'b0) begin errs++; $display("FAIL ch3_toggling: got stuck %b want 0", bus0.stuck[3]); end
    checks++; if (bus0.stuck !== exp_stuck[0] || bus0.duty_out !== exp_duty[0]) begin errs++; $display("FAIL ch3_model: got %b %h want %b %h", bus0.stuck, bus0.duty_out, exp_stuck[0], exp_duty[0]); end
  endtask

  task automatic test_en_drop();
    int n;
    wait_vld(0, 3000, n);
    repeat (500) @(negedge clk);
    bus0.en = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++; if (bus0.vld !== 1'b0 || bus0.duty_out !== exp_duty[0] || bus0.stuck !== exp_stuck[0]) begin
        errs++; $display("FAIL en_low_hold c%0d: got vld %b duty %h want 0 %h", c, bus0.vld, bus0.duty_out, exp_duty[0]); end
    end
    bus0.en = 1'b1;
    wait_vld(0, 3000, n);
    checks++; if (n != 2048) begin errs++; $display("FAIL en_return_latency: got %0d want 2048", n); end
    checks++; if (bus0.duty_out !== exp_duty[0] || bus0.diff_out !== exp_diff[0]) begin errs++; $display("FAIL en_return_model: got %h %h want %h %h", bus0.duty_out, bus0.diff_out, exp_duty[0], exp_diff[0]); end
  endtask

  task automatic test_reset_mid();
    int n;
    wait_vld(0, 3000, n);
    repeat (1000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus0.duty_out !== '0 || bus0.diff_out !== '0 || bus0.stuck !== '0 || bus0.vld !== 1'b0) begin
      errs++; $display("FAIL async_reset: got %h %h %b %b want all 0", bus0.duty_out, bus0.diff_out, bus0.stuck, bus0.vld); end
    checks++; if (bus1.duty_out !== '0) begin errs++; $display("FAIL async_reset_avg: got %h want 0", bus1.duty_out); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_vld(0, 3000, n);
    checks++; if (n != 2048) begin errs++; $display("FAIL reset_release_latency: got %0d want 2048", n); end
    checks++; if (bus0.duty_out !== exp_duty[0] || bus0.stuck !== exp_stuck[0]) begin errs++; $display("FAIL reset_release_model: got %h %b want %h %b", bus0.duty_out, bus0.stuck, exp_duty[0], exp_stuck[0]); end
  endtask

  task automatic test_avg();
    int n;
    bus0.en = 1'b0;
    mode[2] = 2; hia[2] = 1000; hib[2] = 1004; phs[2] = 100;
    repeat (10) @(negedge clk);
    bus0.en = 1'b1; t_base = tc;
    wait_vld(1, 9000, n);
    checks++; if (n != 8192) begin errs++; $display("FAIL avg_first_latency: got %0d want 8192", n); end
    for (int w = 0; w < 2; w++) begin
      if (w == 1) begin
        wait_vld(1, 9000, n);
        checks++; if (n != 8192) begin errs++; $display("FAIL avg_period: got %0d want 8192", n); end
      end
      checks++; if (bus1.duty_out[32:22] !== 11'd1002) begin errs++; $display("FAIL avg_duty_ch2_w%0d: got %0d want 1002", w, bus1.duty_out[32:22]); end
      checks++; if (bus1.duty_out !== exp_duty[1] || bus1.diff_out !== exp_diff[1] || bus1.stuck !== exp_stuck[1]) begin
        errs++; $display("FAIL avg_model_w%0d: got %h %h %b want %h %h %b", w, bus1.duty_out, bus1.diff_out, bus1.stuck, exp_duty[1], exp_diff[1], exp_stuck[1]); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      for (int ch = 0; ch < 4; ch++) begin
        mode[ch] = $urandom_range(0, 3);
        hia[ch]  = $urandom_range(0, 1900);
        hib[ch]  = $urandom_range(0, 1900);
        phs[ch]  = $urandom_range(0, 100);
      end
      wait_vld(0, 3000, n);
      checks++; if (n < 1) begin errs++; $display("FAIL rand_vld_timeout it%0d: got %0d want >0", it, n); end
      checks++; if (bus0.duty_out !== exp_duty[0] || bus0.diff_out !== exp_diff[0] || bus0.stuck !== exp_stuck[0]) begin
        errs++; $display("FAIL rand_model it%0d: got %h %h %b want %h %h %b", it, bus0.duty_out, bus0.diff_out, bus0.stuck, exp_duty[0], exp_diff[0], exp_stuck[0]); end
      checks++; if (bus1.vld !== exp_vld[1]) begin errs++; $display("FAIL rand_avg_vld it%0d: got %b want %b", it, bus1.vld, exp_vld[1]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.en = 1'b0;
    mode = '{0, 0, 0, 0};
    hia = '{0, 0, 0, 0}; hib = '{0, 0, 0, 0}; phs = '{0, 0, 0, 0};
    test_reset();
    test_first_window();
    test_diff();
    test_stuck_toggle();
    test_en_drop();
    test_reset_mid();
    test_avg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
